// File: rtl/apb_if.sv
// apb_if: APB slave register bank for the image-rotation engine.
//
// Decodes single-cycle APB transfers (zero wait states, no error response) into
// configuration and command registers for the rotate core and its DMA, and
// returns core status on reads.
//
// Ports:
//   I_PCLK, I_PRESET_N           clock, asynchronous active-low reset
//   I_PSEL/I_PENABLE/I_PWRITE    APB control
//   I_PADDR, I_PWDATA            APB address (only [7:0] decoded) and write data
//   O_PRDATA, O_PREADY           APB read data and ready (both combinational)
//   I_ROT_IMG_NEW_*, I_CTRL_*    status from the rotate core
//   O_DMA_*, O_ROT_IMG_*         configuration registers and status mirrors
//   O_CTRL_START/RESET/INTR_CLEAR one-cycle command pulses
//   O_CTRL_INTR_MASK             interrupt mask level
//   O_CTRL_BEF/AFT_MASK, O_CTRL_BUSY  registered copies of core status
module apb_if (
  input  logic        I_PCLK,
  input  logic        I_PRESET_N,
  input  logic        I_PSEL,
  input  logic        I_PENABLE,
  input  logic        I_PWRITE,
  input  logic [31:0] I_PADDR,
  input  logic [31:0] I_PWDATA,
  output logic [31:0] O_PRDATA,
  output logic        O_PREADY,
  input  logic [15:0] I_ROT_IMG_NEW_H,
  input  logic [15:0] I_ROT_IMG_NEW_W,
  input  logic        I_CTRL_BEF_MASK,
  input  logic        I_CTRL_AFT_MASK,
  input  logic        I_CTRL_BUSY,
  output logic [31:0] O_DMA_SRC_IMG,
  output logic [31:0] O_DMA_DST_IMG,
  output logic [15:0] O_ROT_IMG_H,
  output logic [15:0] O_ROT_IMG_W,
  output logic [15:0] O_ROT_IMG_NEW_H,
  output logic [15:0] O_ROT_IMG_NEW_W,
  output logic [1:0]  O_ROT_IMG_MODE,
  output logic        O_ROT_IMG_DIR,
  output logic        O_CTRL_START,
  output logic        O_CTRL_RESET,
  output logic        O_CTRL_INTR_CLEAR,
  output logic        O_CTRL_INTR_MASK,
  output logic        O_CTRL_BEF_MASK,
  output logic        O_CTRL_AFT_MASK,
  output logic        O_CTRL_BUSY
);

  // Register offsets.
  localparam logic [7:0] AddrDmaSrc     = 8'h00;
  localparam logic [7:0] AddrDmaDst     = 8'h04;
  localparam logic [7:0] AddrImgH       = 8'h08;
  localparam logic [7:0] AddrImgW       = 8'h0C;
  localparam logic [7:0] AddrImgNewH    = 8'h10;
  localparam logic [7:0] AddrImgNewW    = 8'h14;
  localparam logic [7:0] AddrImgMode    = 8'h18;
  localparam logic [7:0] AddrImgDir     = 8'h1C;
  localparam logic [7:0] AddrStart      = 8'h20;
  localparam logic [7:0] AddrReset      = 8'h24;
  localparam logic [7:0] AddrIntrMask   = 8'h28;
  localparam logic [7:0] AddrBefMask    = 8'h2C;
  localparam logic [7:0] AddrAftMask    = 8'h30;
  localparam logic [7:0] AddrIntrClear  = 8'h34;
  localparam logic [7:0] AddrBusy       = 8'h38;

  logic [7:0] addr;
  logic       wr_en;
  logic       rd_en;

  // Upper address bits are intentionally not decoded (the block aliases every 256 bytes).
  logic unused_paddr;
  assign unused_paddr = ^I_PADDR[31:8];

  assign addr  = I_PADDR[7:0];
  assign wr_en = I_PSEL & I_PENABLE & I_PWRITE;
  assign rd_en = I_PSEL & ~I_PWRITE;

  // Configuration registers.
  logic [31:0] dma_src_q, dma_src_d;
  logic [31:0] dma_dst_q, dma_dst_d;
  logic [15:0] img_h_q, img_h_d;
  logic [15:0] img_w_q, img_w_d;
  logic [1:0]  img_mode_q, img_mode_d;
  logic        img_dir_q, img_dir_d;
  logic        intr_mask_q, intr_mask_d;

  // Command pulses.
  logic        start_q, start_d;
  logic        core_reset_q, core_reset_d;
  logic        intr_clear_q, intr_clear_d;

  // Status samples from the core.
  logic [15:0] img_new_h_q, img_new_h_d;
  logic [15:0] img_new_w_q, img_new_w_d;
  logic        bef_mask_q, bef_mask_d;
  logic        aft_mask_q, aft_mask_d;
  logic        busy_q, busy_d;

  always_comb begin
    dma_src_d    = dma_src_q;
    dma_dst_d    = dma_dst_q;
    img_h_d      = img_h_q;
    img_w_d      = img_w_q;
    img_mode_d   = img_mode_q;
    img_dir_d    = img_dir_q;
    intr_mask_d  = intr_mask_q;

    // Pulses self-clear; they only stay high if a new strobe arrives.
    start_d      = 1'b0;
    core_reset_d = 1'b0;
    intr_clear_d = 1'b0;

    // Status is sampled every cycle regardless of bus activity.
    img_new_h_d  = I_ROT_IMG_NEW_H;
    img_new_w_d  = I_ROT_IMG_NEW_W;
    bef_mask_d   = I_CTRL_BEF_MASK;
    aft_mask_d   = I_CTRL_AFT_MASK;
    busy_d       = I_CTRL_BUSY;

    if (wr_en) begin
      case (addr)
        AddrDmaSrc:    dma_src_d    = I_PWDATA;
        AddrDmaDst:    dma_dst_d    = I_PWDATA;
        AddrImgH:      img_h_d      = I_PWDATA[15:0];
        AddrImgW:      img_w_d      = I_PWDATA[15:0];
        AddrImgMode:   img_mode_d   = I_PWDATA[1:0];
        AddrImgDir:    img_dir_d    = I_PWDATA[0];
        AddrIntrMask:  intr_mask_d  = I_PWDATA[0];
        AddrStart:     start_d      = I_PWDATA[0];
        AddrReset:     core_reset_d = I_PWDATA[0];
        AddrIntrClear: intr_clear_d = I_PWDATA[0];
        // Read-only and unmapped offsets: write is dropped.
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      dma_src_q    <= '0;
      dma_dst_q    <= '0;
      img_h_q      <= '0;
      img_w_q      <= '0;
      img_mode_q   <= '0;
      img_dir_q    <= 1'b0;
      intr_mask_q  <= 1'b0;
      start_q      <= 1'b0;
      core_reset_q <= 1'b0;
      intr_clear_q <= 1'b0;
      img_new_h_q  <= '0;
      img_new_w_q  <= '0;
      bef_mask_q   <= 1'b0;
      aft_mask_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      dma_src_q    <= dma_src_d;
      dma_dst_q    <= dma_dst_d;
      img_h_q      <= img_h_d;
      img_w_q      <= img_w_d;
      img_mode_q   <= img_mode_d;
      img_dir_q    <= img_dir_d;
      intr_mask_q  <= intr_mask_d;
      start_q      <= start_d;
      core_reset_q <= core_reset_d;
      intr_clear_q <= intr_clear_d;
      img_new_h_q  <= img_new_h_d;
      img_new_w_q  <= img_new_w_d;
      bef_mask_q   <= bef_mask_d;
      aft_mask_q   <= aft_mask_d;
      busy_q       <= busy_d;
    end
  end

  // Read mux: pulse registers and unmapped offsets read as zero.
  always_comb begin
    O_PRDATA = '0;
    if (rd_en) begin
      case (addr)
        AddrDmaSrc:   O_PRDATA = dma_src_q;
        AddrDmaDst:   O_PRDATA = dma_dst_q;
        AddrImgH:     O_PRDATA = {16'h0, img_h_q};
        AddrImgW:     O_PRDATA = {16'h0, img_w_q};
        AddrImgNewH:  O_PRDATA = {16'h0, img_new_h_q};
        AddrImgNewW:  O_PRDATA = {16'h0, img_new_w_q};
        AddrImgMode:  O_PRDATA = {30'h0, img_mode_q};
        AddrImgDir:   O_PRDATA = {31'h0, img_dir_q};
        AddrIntrMask: O_PRDATA = {31'h0, intr_mask_q};
        AddrBefMask:  O_PRDATA = {31'h0, bef_mask_q};
        AddrAftMask:  O_PRDATA = {31'h0, aft_mask_q};
        AddrBusy:     O_PRDATA = {31'h0, busy_q};
        default:      O_PRDATA = '0;
      endcase
    end
  end

  assign O_PREADY          = I_PSEL & I_PENABLE;

  assign O_DMA_SRC_IMG     = dma_src_q;
  assign O_DMA_DST_IMG     = dma_dst_q;
  assign O_ROT_IMG_H       = img_h_q;
  assign O_ROT_IMG_W       = img_w_q;
  assign O_ROT_IMG_NEW_H   = img_new_h_q;
  assign O_ROT_IMG_NEW_W   = img_new_w_q;
  assign O_ROT_IMG_MODE    = img_mode_q;
  assign O_ROT_IMG_DIR     = img_dir_q;
  assign O_CTRL_START      = start_q;
  assign O_CTRL_RESET      = core_reset_q;
  assign O_CTRL_INTR_CLEAR = intr_clear_q;
  assign O_CTRL_INTR_MASK  = intr_mask_q;
  assign O_CTRL_BEF_MASK   = bef_mask_q;
  assign O_CTRL_AFT_MASK   = aft_mask_q;
  assign O_CTRL_BUSY       = busy_q;

endmodule

// File: tb/tb_apb_if.sv
// Bench for apb_if: directed steps from the register map followed by random
// traffic, all checked against a table-driven register-map model.
module tb_apb_if;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic [15:0] new_h = '0, new_w = '0;
  logic        bef_m = 1'b0, aft_m = 1'b0, busy = 1'b0;
  logic [31:0] dma_src, dma_dst;
  logic [15:0] img_h, img_w, img_new_h, img_new_w;
  logic [1:0]  img_mode;
  logic        img_dir, c_start, c_reset, c_clr, c_imask, c_bef, c_aft, c_busy;

  apb_if dut (
    .I_PCLK            (pclk),
    .I_PRESET_N        (rst_n),
    .I_PSEL            (psel),
    .I_PENABLE         (penable),
    .I_PWRITE          (pwrite),
    .I_PADDR           (paddr),
    .I_PWDATA          (pwdata),
    .O_PRDATA          (prdata),
    .O_PREADY          (pready),
    .I_ROT_IMG_NEW_H   (new_h),
    .I_ROT_IMG_NEW_W   (new_w),
    .I_CTRL_BEF_MASK   (bef_m),
    .I_CTRL_AFT_MASK   (aft_m),
    .I_CTRL_BUSY       (busy),
    .O_DMA_SRC_IMG     (dma_src),
    .O_DMA_DST_IMG     (dma_dst),
    .O_ROT_IMG_H       (img_h),
    .O_ROT_IMG_W       (img_w),
    .O_ROT_IMG_NEW_H   (img_new_h),
    .O_ROT_IMG_NEW_W   (img_new_w),
    .O_ROT_IMG_MODE    (img_mode),
    .O_ROT_IMG_DIR     (img_dir),
    .O_CTRL_START      (c_start),
    .O_CTRL_RESET      (c_reset),
    .O_CTRL_INTR_CLEAR (c_clr),
    .O_CTRL_INTR_MASK  (c_imask),
    .O_CTRL_BEF_MASK   (c_bef),
    .O_CTRL_AFT_MASK   (c_aft),
    .O_CTRL_BUSY       (c_busy)
  );

  always #5 pclk = ~pclk;

  int n_asserts = 0;
  int n_fail = 0;

  // Register map as a table indexed by word offset (addr >> 2).
  typedef enum int {KNone, KRw, KRo, KPulse} kind_e;

  function automatic kind_e kind_of(input int idx);
    case (idx)
      0, 1, 2, 3, 6, 7, 10: return KRw;
      4, 5, 11, 12, 14:     return KRo;
      8, 9, 13:             return KPulse;
      default:              return KNone;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int idx);
    case (idx)
      0, 1:    return 32'hFFFF_FFFF;
      2, 3:    return 32'h0000_FFFF;
      6:       return 32'h0000_0003;
      default: return 32'h0000_0001;
    endcase
  endfunction

  // Word index of a mapped offset, or -1.
  function automatic int map_idx(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a[7:0] > 8'h38) return -1;
    return int'(a[7:2]);
  endfunction

  logic [31:0] rw_mem [16];
  logic [31:0] ro_mem [16];
  logic        pulse  [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      rw_mem[i] = '0;
      ro_mem[i] = '0;
      pulse[i]  = 1'b0;
    end
  endtask

  // Applies one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 16; i++) pulse[i] = 1'b0;
    ro_mem[4]  = {16'h0, new_h};
    ro_mem[5]  = {16'h0, new_w};
    ro_mem[11] = {31'h0, bef_m};
    ro_mem[12] = {31'h0, aft_m};
    ro_mem[14] = {31'h0, busy};
    if (psel && penable && pwrite) begin
      idx = map_idx(paddr);
      if (idx >= 0) begin
        if (kind_of(idx) == KRw)    rw_mem[idx] = pwdata & mask_of(idx);
        if (kind_of(idx) == KPulse) pulse[idx]  = pwdata[0];
      end
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    int idx;
    if (!(psel && !pwrite)) return '0;
    idx = map_idx(paddr);
    if (idx < 0) return '0;
    if (kind_of(idx) == KRw) return rw_mem[idx];
    if (kind_of(idx) == KRo) return ro_mem[idx];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("prdata",     prdata,    exp_rdata());
    chk("pready",     {31'h0, pready}, {31'h0, psel & penable});
    chk("dma_src",    dma_src,   rw_mem[0]);
    chk("dma_dst",    dma_dst,   rw_mem[1]);
    chk("img_h",      {16'h0, img_h},     rw_mem[2]);
    chk("img_w",      {16'h0, img_w},     rw_mem[3]);
    chk("img_new_h",  {16'h0, img_new_h}, ro_mem[4]);
    chk("img_new_w",  {16'h0, img_new_w}, ro_mem[5]);
    chk("img_mode",   {30'h0, img_mode},  rw_mem[6]);
    chk("img_dir",    {31'h0, img_dir},   rw_mem[7]);
    chk("start",      {31'h0, c_start},   {31'h0, pulse[8]});
    chk("core_reset", {31'h0, c_reset},   {31'h0, pulse[9]});
    chk("intr_mask",  {31'h0, c_imask},   rw_mem[10]);
    chk("bef_mask",   {31'h0, c_bef},     ro_mem[11]);
    chk("aft_mask",   {31'h0, c_aft},     ro_mem[12]);
    chk("intr_clear", {31'h0, c_clr},     {31'h0, pulse[13]});
    chk("busy",       {31'h0, c_busy},    ro_mem[14]);
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge,
  // then return 1 time unit after the edge so the caller can drive new inputs.
  task automatic cycle();
    @(negedge pclk);
    check_outputs();
    @(posedge pclk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    cycle();
    penable = 1'b1;
    cycle();
    idle();
  endtask

  task automatic apb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    cycle();
    penable = 1'b1;
    #1;
    chk(tag, prdata, exp);
    cycle();
    idle();
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    // Status inputs are nonzero but must not be captured while in reset.
    new_h = 16'hABCD; new_w = 16'h1234; bef_m = 1'b1; aft_m = 1'b1; busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'(i * 4);
      #1;
      chk("reset_rd", prdata, 32'h0);
      cycle();
    end
    idle();
    rst_n = 1'b1;
    new_h = '0; new_w = '0; bef_m = 1'b0; aft_m = 1'b0; busy = 1'b0;
    cycle();
    cycle();

    // Basic configuration.
    apb_write(32'h00, 32'd20);
    apb_write(32'h04, 32'd7000);
    apb_write(32'h08, 32'd5);
    apb_write(32'h0C, 32'd8);
    apb_write(32'h18, 32'd2);
    apb_write(32'h1C, 32'd1);
    chk("cfg_src",  dma_src, 32'd20);
    chk("cfg_dst",  dma_dst, 32'd7000);
    chk("cfg_h",    {16'h0, img_h}, 32'd5);
    chk("cfg_w",    {16'h0, img_w}, 32'd8);
    chk("cfg_mode", {30'h0, img_mode}, 32'd2);
    chk("cfg_dir",  {31'h0, img_dir}, 32'd1);
    apb_read(32'h00, 32'd20,   "rd_src");
    apb_read(32'h04, 32'd7000, "rd_dst");
    apb_read(32'h08, 32'd5,    "rd_h");
    apb_read(32'h0C, 32'd8,    "rd_w");
    apb_read(32'h18, 32'd2,    "rd_mode");
    apb_read(32'h1C, 32'd1,    "rd_dir");

    // Read-only registers ignore writes and track the core.
    new_h = 16'd8;
    apb_write(32'h10, 32'd20);
    chk("ro_new_h", {16'h0, img_new_h}, 32'd8);
    apb_read(32'h10, 32'd8, "rd_new_h");
    new_w = 16'd7000;
    apb_write(32'h14, 32'd7000 + 32'd5);
    chk("ro_new_w", {16'h0, img_new_w}, 32'd7000);
    apb_read(32'h14, 32'd7000, "rd_new_w");

    // Start pulse: exactly one cycle, reads as zero.
    apb_write(32'h20, 32'd1);
    chk("start_hi", {31'h0, c_start}, 32'd1);
    cycle();
    chk("start_lo", {31'h0, c_start}, 32'd0);
    apb_read(32'h20, 32'd0, "rd_start");
    apb_write(32'h24, 32'd0);
    chk("reset_zero_wr", {31'h0, c_reset}, 32'd0);

    // PENABLE held across cycles: each cycle is a separate write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'd1;
    cycle();
    penable = 1'b1;
    cycle();
    chk("b2b_start1", {31'h0, c_start}, 32'd1);
    cycle();
    chk("b2b_start2", {31'h0, c_start}, 32'd1);
    paddr = 32'h34;
    cycle();
    chk("b2b_start3", {31'h0, c_start}, 32'd0);
    chk("b2b_clear",  {31'h0, c_clr},   32'd1);
    idle();
    cycle();

    // Upper data bits dropped; unmapped offsets inert.
    apb_write(32'h18, 32'hFFFF_FFFF);
    chk("mode_trunc", {30'h0, img_mode}, 32'd3);
    apb_read(32'h18, 32'h3, "rd_mode_trunc");
    apb_write(32'h40, 32'hDEAD_BEEF);
    chk("unmapped_src", dma_src, 32'd20);
    apb_read(32'h40, 32'h0, "rd_unmapped");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] lo;
      case ($urandom_range(0, 9))
        0:       lo = 8'($urandom_range(0, 255));
        1:       lo = 8'($urandom_range(15, 63)) << 2;
        default: lo = 8'($urandom_range(0, 14)) << 2;
      endcase
      psel    = ($urandom_range(0, 3) != 0);
      penable = $urandom_range(0, 1) == 1;
      pwrite  = $urandom_range(0, 1) == 1;
      paddr   = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, lo};
      pwdata  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      new_h   = 16'($urandom);
      new_w   = 16'($urandom);
      bef_m   = 1'($urandom);
      aft_m   = 1'($urandom);
      busy    = 1'($urandom);
      cycle();
    end
    idle();

    // Configure, then assert reset away from a clock edge.
    apb_write(32'h00, 32'h1234_5678);
    apb_write(32'h28, 32'd1);
    chk("pre_rst_src",  dma_src, 32'h1234_5678);
    chk("pre_rst_mask", {31'h0, c_imask}, 32'd1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5555_5555;
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    idle();
    #1;
    check_outputs();
    chk("async_src", dma_src, 32'h0);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_dst", dma_dst, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
